// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter for a single-port data memory.
//
// m0 (core) has priority over m1 (loader/debug). A saturating counter tracks
// how many consecutive cycles m1 has been refused; when it reaches
// STARVE_LIMIT, m1 wins the next contested cycle. Reads return one cycle
// after the grant on the port that issued them. Writes finish in the grant
// cycle.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   m0_req/we/addr/wdata      core request (held until m0_gnt)
//   m0_gnt                    core request accepted this cycle
//   m0_rvalid/m0_rdata        core read return (rdata is 0 unless rvalid)
//   m1_*                      same set of ports for the loader/debug side
//   mem_en/we/addr/wdata      memory strobe and command, 0 when idle
//   mem_rdata                 memory read data, one cycle after a read strobe
//   starve_cnt                current m1 denial count (debug)
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    starve_cnt
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt_reg;
    logic [2:0] starve_cnt_next;
    logic       rd_pend_reg;
    logic       rd_pend_next;
    logic       rd_owner_reg;   // 0 = m0, 1 = m1
    logic       rd_owner_next;

    logic [1:0]    rvalid_vec;
    logic [DW-1:0] rdata_vec [2];

    // ------------------------------------------------------------------
    // Grant and memory command mux. Grants are forced low while rst is
    // high so nothing reaches memory during reset.
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                // m1 wins only once it has been refused LIMIT times in a row
                if (starve_cnt_reg >= LIMIT) begin
                    m1_gnt = 1'b1;
                end else begin
                    m0_gnt = 1'b1;
                end
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: starvation counter and read-return tracking.
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_next = 3'd0;
        if (m1_req && !m1_gnt) begin
            starve_cnt_next = (starve_cnt_reg >= LIMIT) ? LIMIT : starve_cnt_reg + 3'd1;
        end
        // A read is pending next cycle only if one is granted now; a
        // write never produces a return.
        rd_pend_next  = mem_en && !mem_we;
        rd_owner_next = m1_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= 3'd0;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rd_pend_reg    <= rd_pend_next;
            rd_owner_reg   <= rd_owner_next;
        end
    end

    assign starve_cnt = starve_cnt_reg;

    // ------------------------------------------------------------------
    // Read return steering: one slice per requester. Index gi matches the
    // encoding of rd_owner_reg. rdata is held at zero unless that port's
    // rvalid is high so the idle port never shows memory traffic.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign rvalid_vec[gi] = rd_pend_reg && (rd_owner_reg == 1'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : '0;
        end
    endgenerate

    assign m0_rvalid = rvalid_vec[0];
    assign m1_rvalid = rvalid_vec[1];
    assign m0_rdata  = rdata_vec[0];
    assign m1_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by constrained-random
// traffic, checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 0, m0_we = 0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 0, m1_we = 0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [2:0]    starve_cnt;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: synchronous read, data valid one cycle
    // after the strobe; unrelated garbage otherwise so leaks are visible.
    logic [DW-1:0] tb_mem [0:63];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            tb_mem[mem_addr[7:2]] <= mem_wdata;
            mem_rdata <= $urandom;
        end else if (mem_en) begin
            mem_rdata <= tb_mem[mem_addr[7:2]];
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // Reference model state (transaction level)
    logic [DW-1:0] ref_mem [0:63];
    int            cnt_m;
    bit            pend_m;
    bit            own_m;
    logic [DW-1:0] pdata_m;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle of requests (called at posedge+1), checks all DUT
    // outputs mid-cycle against the model, then advances the model across
    // the clock edge. Returns the grants the model predicted.
    task automatic apply(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         output bit g0, output bit g1);
        bit eg0, eg1, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #3;
        eg0 = r0 && (!r1 || cnt_m < LIM);
        eg1 = r1 && !eg0;
        ew  = eg0 ? w0 : (eg1 ? w1 : 1'b0);
        ea  = eg0 ? a0 : (eg1 ? a1 : '0);
        ed  = eg0 ? d0 : (eg1 ? d1 : '0);
        chk("m0_gnt", 64'(m0_gnt), 64'(eg0));
        chk("m1_gnt", 64'(m1_gnt), 64'(eg1));
        chk("mem_en", 64'(mem_en), 64'(eg0 | eg1));
        chk("mem_we", 64'(mem_we), 64'(ew));
        chk("mem_addr", 64'(mem_addr), 64'(ea));
        chk("mem_wdata", 64'(mem_wdata), 64'(ed));
        chk("starve_cnt", 64'(starve_cnt), 64'(cnt_m));
        chk("m0_rvalid", 64'(m0_rvalid), 64'(pend_m && !own_m));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(pend_m && own_m));
        chk("m0_rdata", 64'(m0_rdata), 64'((pend_m && !own_m) ? pdata_m : '0));
        chk("m1_rdata", 64'(m1_rdata), 64'((pend_m && own_m) ? pdata_m : '0));
        $display("cyc t=%0t req=%0b%0b gnt=%0b%0b we=%0b addr=%0h cnt=%0d rv=%0b%0b",
                 $time, r0, r1, eg0, eg1, ew, ea, cnt_m, pend_m && !own_m, pend_m && own_m);
        // model advance
        if (r1 && !eg1) cnt_m = (cnt_m + 1 > LIM) ? LIM : cnt_m + 1;
        else            cnt_m = 0;
        pend_m = (eg0 || eg1) && !ew;
        own_m  = eg1;
        if (pend_m) pdata_m = ref_mem[ea[7:2]];
        if ((eg0 || eg1) && ew) ref_mem[ea[7:2]] = ed;
        g0 = eg0;
        g1 = eg1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_m0_gnt"}, 64'(m0_gnt), 64'd0);
        chk({pfx, "_m1_gnt"}, 64'(m1_gnt), 64'd0);
        chk({pfx, "_mem_en"}, 64'(mem_en), 64'd0);
        chk({pfx, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({pfx, "_m0_rvalid"}, 64'(m0_rvalid), 64'd0);
        chk({pfx, "_m1_rvalid"}, 64'(m1_rvalid), 64'd0);
        chk({pfx, "_m0_rdata"}, 64'(m0_rdata), 64'd0);
        chk({pfx, "_m1_rdata"}, 64'(m1_rdata), 64'd0);
        chk({pfx, "_starve"}, 64'(starve_cnt), 64'd0);
    endtask

    initial begin
        bit g0, g1;
        bit r0, w0, r1, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;

        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[0]  = 32'd9;  ref_mem[0]  = 32'd9;
        tb_mem[1]  = 32'h11; ref_mem[1]  = 32'h11;
        tb_mem[2]  = 32'h22; ref_mem[2]  = 32'h22;
        tb_mem[3]  = 32'h33; ref_mem[3]  = 32'h33;
        cnt_m = 0; pend_m = 0; own_m = 0; pdata_m = '0;

        // Reset state, with requests present: nothing may be granted
        m0_req = 1; m0_addr = 32'h4; m1_req = 1; m1_we = 1; m1_addr = 32'h8;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        // m0 read @0 returns 9 on m0 only
        apply(1, 0, 32'h0, 0, 0, 0, 0, 0, g0, g1);
        // m1 write @0x10 data 6; no read return following
        apply(0, 0, 0, 0, 1, 1, 32'h10, 32'h6, g0, g1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        // Read back what m1 wrote
        apply(1, 0, 32'h10, 0, 0, 0, 0, 0, g0, g1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Continuous contention: 4 grants to m0, then m1, repeated twice
        for (int i = 0; i < 10; i++)
            apply(1, 0, 32'(i * 4), 0, 1, 0, 32'(8'h80 + i * 4), 0, g0, g1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Alternating back-to-back reads
        apply(1, 0, 32'h4, 0, 0, 0, 0, 0, g0, g1);
        apply(0, 0, 0, 0, 1, 0, 32'h8, 0, g0, g1);
        apply(1, 0, 32'hC, 0, 0, 0, 0, 0, g0, g1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Withdrawn m1 request clears the counter
        apply(1, 0, 0, 0, 1, 0, 32'h20, 0, g0, g1);
        apply(1, 0, 0, 0, 1, 0, 32'h20, 0, g0, g1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Random traffic; an ungranted request is usually held, sometimes dropped
        r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        g0 = 1; g1 = 1;
        for (int i = 0; i < 300; i++) begin
            if (!(r0 && !g0 && $urandom_range(7) != 0)) begin
                r0 = ($urandom_range(2) != 0);
                w0 = $urandom_range(1);
                a0 = 32'($urandom_range(63)) << 2;
                d0 = $urandom;
            end
            if (!(r1 && !g1 && $urandom_range(7) != 0)) begin
                r1 = ($urandom_range(2) != 0);
                w1 = $urandom_range(1);
                a1 = 32'($urandom_range(63)) << 2;
                d1 = $urandom;
            end
            apply(r0, w0, a0, d0, r1, w1, a1, d1, g0, g1);
        end

        // Reset mid-read: read granted in cycle N, rst rises before edge N+1
        apply(0, 0, 0, 0, 1, 0, 32'h4, 0, g0, g1);
        m0_req = 1; m0_we = 0; m0_addr = 32'h8; m0_wdata = '0;
        m1_req = 1; m1_we = 0; m1_addr = 32'hC; m1_wdata = '0;
        #3;
        chk("mr_m0_gnt_pre", 64'(m0_gnt), 64'd1);
        chk("mr_m1_rvalid_pre", 64'(m1_rvalid), 64'd1);
        rst = 1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        chk_all_zero("midrst_hold");
        rst = 0;
        cnt_m = 0; pend_m = 0; own_m = 0;
        // After release: no stale rvalid, and the first grant is immediate
        apply(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        apply(0, 0, 0, 0, 1, 0, 32'h8, 0, g0, g1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
